// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter for one FIFO write port.
// Two producers share wrreq/data; writes throttled on full/fill count.
module fifo_wr_arb #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int DEPTH     = 256,
    parameter int MAX_BURST = 16,
    parameter int GUARD     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    input  logic          s0_last,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    input  logic          s1_last,
    output logic          s1_ready,
    input  logic          fifo_full_flag,
    input  logic [AW-1:0] fifo_wrusedw,
    output logic          fifo_wr_flag,
    output logic [DW-1:0] fifo_wr_data,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          ovf_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST0 = 2'd1,
        BURST1 = 2'd2
    } state_t;

    // Highest fill count that still leaves GUARD words for in-flight writes
    localparam logic [AW:0] FREE_LIM = (AW+1)'(DEPTH - 1 - GUARD);
    localparam logic [7:0]  CNT_END  = 8'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          wr_flag_q, wr_flag_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          ovf_q, ovf_d;

    logic          space_ok;
    logic          acc0, acc1, acc;
    logic [DW-1:0] acc_data;
    logic          acc_last;

    // wrusedw wraps to 0 at true full, so the full flag gates as well
    assign space_ok = !fifo_full_flag && ({1'b0, fifo_wrusedw} <= FREE_LIM);

    assign s0_ready = (state_q == BURST0) && space_ok;
    assign s1_ready = (state_q == BURST1) && space_ok;

    assign acc0     = s0_valid && s0_ready;
    assign acc1     = s1_valid && s1_ready;
    assign acc      = acc0 || acc1;
    assign acc_data = acc1 ? s1_data : s0_data;
    assign acc_last = acc1 ? s1_last : s0_last;

    // Next state: tie goes to the source that did not win last time
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (s0_valid && (!s1_valid || last_grant_q)) begin
                    state_d      = BURST0;
                    last_grant_d = 1'b0;
                    beat_cnt_d   = 8'd0;
                end else if (s1_valid) begin
                    state_d      = BURST1;
                    last_grant_d = 1'b1;
                    beat_cnt_d   = 8'd0;
                end
            end
            BURST0, BURST1: begin
                if (acc) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (acc_last || beat_cnt_q == CNT_END) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered write port and sticky overflow flag
    always_comb begin
        wr_flag_d = acc;
        wr_data_d = acc ? acc_data : wr_data_q;
        ovf_d     = ovf_q || (wr_flag_q && fifo_full_flag);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            wr_flag_q    <= 1'b0;
            wr_data_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_flag_q    <= wr_flag_d;
            wr_data_q    <= wr_data_d;
            ovf_q        <= ovf_d;
        end
    end

    assign fifo_wr_flag = wr_flag_q;
    assign fifo_wr_data = wr_data_q;
    assign grant        = {state_q == BURST1, state_q == BURST0};
    assign busy         = (state_q != IDLE);
    assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenario tests for fifo_wr_arb.
// Inputs change 1ns after the rising edge; outputs sampled there.
module tb_fifo_wr_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s0_valid, s0_last, s0_ready;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s1_data;
    logic       fifo_full_flag;
    logic [7:0] fifo_wrusedw;
    logic       fifo_wr_flag;
    logic [7:0] fifo_wr_data;
    logic [1:0] grant;
    logic       busy;
    logic       ovf_err;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arb #(
        .DW(8), .AW(8), .DEPTH(256), .MAX_BURST(16), .GUARD(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data),
        .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data),
        .s1_last(s1_last), .s1_ready(s1_ready),
        .fifo_full_flag(fifo_full_flag),
        .fifo_wrusedw(fifo_wrusedw),
        .fifo_wr_flag(fifo_wr_flag),
        .fifo_wr_data(fifo_wr_data),
        .grant(grant), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        s0_valid       = 1'b0;
        s0_data        = 8'h00;
        s0_last        = 1'b0;
        s1_valid       = 1'b0;
        s1_data        = 8'h00;
        s1_last        = 1'b0;
        fifo_full_flag = 1'b0;
        fifo_wrusedw   = 8'd0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({fifo_wr_flag, grant, busy, ovf_err, s0_ready, s1_ready} !== 7'b0
            || fifo_wr_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: flag=%b grant=%b busy=%b ovf=%b rdy=%b%b data=%h, required all 0",
                     fifo_wr_flag, grant, busy, ovf_err, s0_ready, s1_ready, fifo_wr_data);
        end
    endtask

    task automatic test_single_burst;
        do_reset;
        s0_valid = 1'b1;
        s0_data  = 8'hA0;
        tick;
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: grant=%b busy=%b, required 01/1", grant, busy);
        end
        for (int i = 0; i < 4; i++) begin
            s0_data = 8'(8'hA0 + i);
            s0_last = (i == 3);
            #1;
            checks++;
            if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_ready%0d: rdy=%b%b, required 1/0", i, s0_ready, s1_ready);
            end
            tick;
            checks++;
            if (fifo_wr_flag !== 1'b1 || fifo_wr_data !== 8'(8'hA0 + i)) begin
                failures++;
                $display("FAIL single_write%0d: flag=%b data=%h, required 1/%h",
                         i, fifo_wr_flag, fifo_wr_data, 8'(8'hA0 + i));
            end
        end
        s0_valid = 1'b0;
        s0_last  = 1'b0;
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: grant=%b busy=%b, required 00/0", grant, busy);
        end
        tick;
        checks++;
        if (fifo_wr_flag !== 1'b0 || fifo_wr_data !== 8'hA3) begin
            failures++;
            $display("FAIL single_after: flag=%b data=%h, required 0/a3", fifo_wr_flag, fifo_wr_data);
        end
    endtask

    task automatic test_contention;
        int k0, k1;
        logic a0, a1;
        logic [7:0] got[$];
        logic [7:0] exp [8];
        exp = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
        do_reset;
        k0 = 0;
        k1 = 0;
        s0_valid = 1'b1; s0_data = 8'h10; s0_last = 1'b0;
        s1_valid = 1'b1; s1_data = 8'h20; s1_last = 1'b0;
        for (int t = 0; t < 12; t++) begin
            #1;
            a0 = s0_valid && s0_ready;
            a1 = s1_valid && s1_ready;
            tick;
            if (t == 0) begin
                checks++;
                if (grant !== 2'b01) begin
                    failures++;
                    $display("FAIL contend_first: grant=%b, required 01", grant);
                end
            end
            if (fifo_wr_flag) got.push_back(fifo_wr_data);
            if (a0) begin
                k0++;
                s0_data = 8'(8'h10 + k0);
                s0_last = (k0 % 2 == 1);
            end
            if (a1) begin
                k1++;
                s1_data = 8'(8'h20 + k1);
                s1_last = (k1 % 2 == 1);
            end
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        checks++;
        if (got.size() !== 8) begin
            failures++;
            $display("FAIL contend_count: writes=%0d, required 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL contend_order%0d: data=%h, required %h", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_truncation;
        int k, run, gap_seen;
        logic a1;
        logic [7:0] got[$];
        do_reset;
        k = 0;
        run = 0;
        gap_seen = 0;
        s1_valid = 1'b1; s1_data = 8'h40; s1_last = 1'b0;
        for (int t = 0; t < 30; t++) begin
            #1;
            a1 = s1_valid && s1_ready;
            tick;
            if (fifo_wr_flag) begin
                got.push_back(fifo_wr_data);
                if (gap_seen == 0) run++;
            end else if (run > 0) begin
                gap_seen = 1;
            end
            if (a1) begin
                k++;
                s1_data = 8'(8'h40 + k);
                s1_last = (k == 19);
                if (k == 20) s1_valid = 1'b0;
            end
        end
        s1_last = 1'b0;
        checks++;
        if (run !== 16) begin
            failures++;
            $display("FAIL trunc_first_run: beats=%0d, required 16", run);
        end
        checks++;
        if (got.size() !== 20) begin
            failures++;
            $display("FAIL trunc_total: writes=%0d, required 20", got.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (got[i] !== 8'(8'h40 + i)) begin
                    failures++;
                    $display("FAIL trunc_data%0d: data=%h, required %h", i, got[i], 8'(8'h40 + i));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        fifo_wrusedw = 8'd254;
        s0_valid = 1'b1; s0_data = 8'h55; s0_last = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b01 || s0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_254_ready: grant=%b rdy=%b, required 01/0", grant, s0_ready);
        end
        tick;
        tick;
        checks++;
        if (fifo_wr_flag !== 1'b0) begin
            failures++;
            $display("FAIL bp_254_nowrite: flag=%b, required 0", fifo_wr_flag);
        end
        fifo_wrusedw = 8'd253;
        #1;
        checks++;
        if (s0_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_253_ready: rdy=%b, required 1", s0_ready);
        end
        fifo_full_flag = 1'b1;
        fifo_wrusedw   = 8'd0;
        #1;
        checks++;
        if (s0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_ready: rdy=%b, required 0", s0_ready);
        end
        tick;
        checks++;
        if (fifo_wr_flag !== 1'b0 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_nowrite: flag=%b ovf=%b, required 0/0", fifo_wr_flag, ovf_err);
        end
        fifo_full_flag = 1'b0;
        tick;
        s0_valid = 1'b0;
        s0_last  = 1'b0;
        checks++;
        if (fifo_wr_flag !== 1'b1 || fifo_wr_data !== 8'h55 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_write: flag=%b data=%h ovf=%b, required 1/55/0",
                     fifo_wr_flag, fifo_wr_data, ovf_err);
        end
        fifo_full_flag = 1'b1;
        tick;
        checks++;
        if (ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL bp_ovf_set: ovf=%b, required 1", ovf_err);
        end
        fifo_full_flag = 1'b0;
        tick;
        checks++;
        if (ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL bp_ovf_sticky: ovf=%b, required 1", ovf_err);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        s0_valid = 1'b1; s0_data = 8'h60; s0_last = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            s0_data = 8'(8'h60 + i);
            tick;
        end
        s0_data = 8'h63;
        checks++;
        if (fifo_wr_flag !== 1'b1 || fifo_wr_data !== 8'h62 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: flag=%b data=%h busy=%b, required 1/62/1",
                     fifo_wr_flag, fifo_wr_data, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_wr_flag, grant, busy, s0_ready, s1_ready} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_async: flag=%b grant=%b busy=%b rdy=%b%b, required all 0",
                     fifo_wr_flag, grant, busy, s0_ready, s1_ready);
        end
        s1_valid = 1'b1; s1_data = 8'h70; s1_last = 1'b1;
        s0_last  = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_tie: grant=%b, required 01", grant);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_last  = 1'b0; s1_last  = 1'b0;
    endtask

    task automatic test_single_beat;
        do_reset;
        s0_valid = 1'b1; s0_data = 8'h77; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h88; s1_last = 1'b1;
        tick;
        tick;
        s0_valid = 1'b0;
        checks++;
        if (fifo_wr_flag !== 1'b1 || fifo_wr_data !== 8'h77 || grant !== 2'b00) begin
            failures++;
            $display("FAIL sb_s0_write: flag=%b data=%h grant=%b, required 1/77/00",
                     fifo_wr_flag, fifo_wr_data, grant);
        end
        tick;
        checks++;
        if (fifo_wr_flag !== 1'b0 || grant !== 2'b10) begin
            failures++;
            $display("FAIL sb_gap: flag=%b grant=%b, required 0/10", fifo_wr_flag, grant);
        end
        tick;
        s1_valid = 1'b0;
        checks++;
        if (fifo_wr_flag !== 1'b1 || fifo_wr_data !== 8'h88 || grant !== 2'b00) begin
            failures++;
            $display("FAIL sb_s1_write: flag=%b data=%h grant=%b, required 1/88/00",
                     fifo_wr_flag, fifo_wr_data, grant);
        end
    endtask

    initial begin
        test_reset;
        test_single_burst;
        test_contention;
        test_truncation;
        test_backpressure;
        test_reset_mid_burst;
        test_single_beat;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
